// File: rtl/sub_32_serial_if.sv
// rtl/sub_32_serial_if.sv - start/busy/done handshake and operand/result bundle for sub_32_serial
interface sub_32_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow, zero
    );
endinterface

// File: rtl/sub_32_serial.sv
// rtl/sub_32_serial.sv - multi-cycle a - b - bin subtractor, STEP bits per cycle; SUB_ZERO_FLAG_EN adds zero flag
module sub_32_serial #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    sub_32_serial_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
`ifdef SUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic [STEP:0]    slice_full;
    logic [STEP-1:0]  slice;
    logic             slice_borrow;
    logic [WIDTH-1:0] res_next;

    // One STEP-wide borrow subtract; the extra top bit goes negative exactly when a borrow is needed.
    assign slice_full   = {1'b0, a_q[STEP-1:0]} - {1'b0, b_q[STEP-1:0]} - {{STEP{1'b0}}, borrow_q};
    assign slice        = slice_full[STEP-1:0];
    assign slice_borrow = slice_full[STEP];
    assign res_next     = {slice, res_q[WIDTH-1:STEP]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
`ifdef SUB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d      = a_q >> STEP;
                b_d      = b_q >> STEP;
                res_d    = res_next;
                borrow_d = slice_borrow;
                cnt_d    = cnt_q + CW'(1);
                // Results are published only here, so partial slices never reach the outputs.
                if (cnt_q == CW'(N - 1)) begin
                    diff_d  = res_next;
                    bout_d  = slice_borrow;
                    ovf_d   = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`ifdef SUB_ZERO_FLAG_EN
                    zero_d  = (res_next == '0);
`endif
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.bout     = bout_q;
    assign bus.overflow = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
    assign bus.zero     = zero_q;
`else
    assign bus.zero     = 1'b0;
`endif
endmodule

// File: doc/sub_32_serial.md
# sub_32_serial

Multi-cycle 32-bit subtractor computing `diff = a - b - bin` over several clock cycles, STEP bits per cycle, with borrow-out and signed-overflow flags. It is the inverse-direction companion to the combinational 32-bit ripple adder in the datapath. It is used where area matters more than latency, such as compare and decrement paths in the multi-cycle ALU. A start/busy/done handshake lets a controlling FSM launch one operation and collect the result.

## Interface
- `WIDTH`, default 32: operand width in bits.
- `STEP`, default 4: bits processed per cycle; must divide WIDTH; N = WIDTH/STEP (default 8).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request; accepted on a rising edge when `busy`=0.
- `a` input WIDTH: minuend, sampled only at accept.
- `b` input WIDTH: subtrahend, sampled only at accept.
- `bin` input 1: borrow-in, sampled only at accept.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; result valid.
- `diff` output WIDTH: `a - b - bin` mod 2^WIDTH; held until next accept.
- `bout` output 1: unsigned borrow-out; 1 iff a < b + bin.
- `overflow` output 1: signed overflow; (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- `zero` output 1: diff == 0; only when SUB_ZERO_FLAG_EN is defined, else tied 0.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; `busy`, `done`, `diff`, `bout`, `overflow`, `zero` all 0; slice counter 0.
- IDLE or DONE with `start`=1:
  - Latch `a`, `b`; initialise internal borrow from `bin`; counter 0.
  - Go to RUN, `busy`=1.
- RUN, each cycle:
  - Subtract the lowest STEP bits of the working operands with the running borrow.
  - Shift the STEP-bit result slice into the result register from the MSB end.
  - Shift the operand registers right by STEP; update borrow; counter +1.
- RUN, on the cycle the counter reaches N-1:
  - Next edge writes the final slice into `diff` and sets `bout` to the final borrow.
  - `overflow` is computed from the latched operand MSBs and the final diff MSB.
  - `zero` is updated if compiled in.
  - Go to DONE: `done`=1, `busy`=0.
- DONE lasts one cycle (`done`=1), then IDLE unless a new start is accepted in that cycle.
- `start` while `busy`=1 is ignored; in-flight operands are unaffected.
- Inputs `a`/`b`/`bin` may change freely after accept.
- `diff`/flags change only at the completing edge; they are not visible partially during RUN.
- Reset mid-operation: abort immediately, all outputs 0, no `done` pulse.
- Reset has priority over `start` in the same cycle.

## Timing
- Accept at edge k: `busy`=1 from k.
- Completion at edge k+N: `done`=1 and results valid for cycle k+N to k+N+1; `busy`=0 at edge k+N.
- Default latency is 8 cycles from accept to `done`.
- Back-to-back: `start` held during the DONE cycle is accepted at edge k+N+1. Throughput is one operation per N+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `SUB_ZERO_FLAG_EN` defined: zero-detect register is included; `zero` is updated at completion and cleared by reset.
- `SUB_ZERO_FLAG_EN` undefined: no zero logic; `zero` is constant 0.
- All other behaviour is identical in both builds.

## Test plan
- a=5, b=3, bin=0, start pulse: `done` 8 cycles after accept; diff=0x00000002, bout=0, overflow=0.
- a=0, b=1: diff=0xFFFFFFFF, bout=1, overflow=0.
- a=0x80000000, b=1: diff=0x7FFFFFFF, overflow=1, bout=0.
- a=10, b=3, bin=1: diff=6.
- a=7, b=7: diff=0; zero=1 with SUB_ZERO_FLAG_EN, zero=0 without.
- Busy/reset handling:
  - Start a=100, b=1, then at cycle 3 pulse start with a=0, b=0: result is still 99.
  - New run with reset at cycle 4: all outputs 0, no `done`, next start completes normally.
